sqrt_vec_issue: RTL and testbench



---
 rtl/sqrt_pkg.sv | 10 +
 rtl/sqrt_vec_lane_scan.sv | 14 +
 rtl/sqrt_vec_issue.sv | 95 +++++++++
 tb/tb_sqrt_vec_issue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared types and BF16 constants for the sqrt vector issue block
package sqrt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sqrt_vec_state_t;
  localparam int BF16_W = 16;
  localparam logic [BF16_W-1:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [BF16_W-1:0] BF16_NEG_ZERO = 16'h8000;
  function automatic logic bf16_is_zero(input logic [BF16_W-1:0] x);
    return x == BF16_POS_ZERO || x == BF16_NEG_ZERO;
  endfunction
endpackage

// File: rtl/sqrt_vec_lane_scan.sv
// sqrt_vec_lane_scan: first unskipped lane at or after idx, or LANES when none remain
module sqrt_vec_lane_scan #(
  parameter int LANES = 16,
  parameter int IW = $clog2(LANES) + 1
) (
  input  logic [LANES-1:0] skip,
  input  logic [IW-1:0]    idx,
  output logic [IW-1:0]    nxt
);
  always_comb begin
    nxt = IW'(LANES);
    for (int i = LANES - 1; i >= 0; i--) nxt = (!skip[i] && IW'(i) >= idx) ? IW'(i) : nxt;
  end
endmodule

// File: rtl/sqrt_vec_issue.sv
// sqrt_vec_issue: issues a BF16 vector lane by lane to a scalar sqrt unit and gathers results in order
// Optional: SQRT_VEC_ZERO_SKIP_EN bypasses +/-0 lanes, echoing the operand as the result
module sqrt_vec_issue
  import sqrt_pkg::*;
#(
  parameter int LANES = 16,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       vec_valid_in,
  output logic                       vec_ready_in,
  input  logic [LANES*BF16_W-1:0]    vec_operand,
  output logic                       vec_valid_out,
  input  logic                       vec_ready_out,
  output logic [LANES*BF16_W-1:0]    vec_result,
  output logic [BF16_W-1:0]          sq_operand,
  output logic                       sq_valid_in,
  input  logic                       sq_ready_in,
  input  logic                       sq_valid_out,
  output logic                       sq_ready_out,
  input  logic [BF16_W-1:0]          sq_result
);
  localparam int IW = $clog2(LANES) + 1;
  localparam int FW = $clog2(MAX_INFLIGHT + 1);
  sqrt_vec_state_t state_q, state_d;
  logic [LANES-1:0][BF16_W-1:0] ops_q, ops_d, res_q, res_d, pre;
  logic [IW-1:0] issue_q, issue_d, collect_q, collect_d, issue_ptr, collect_ptr;
  logic [FW-1:0] inflight_q, inflight_d;
  logic [LANES-1:0] skip, rest;
  logic issue_fire, collect_fire;
  always_comb begin
    skip = '0;
    pre = '0;
`ifdef SQRT_VEC_ZERO_SKIP_EN
    for (int i = 0; i < LANES; i++) begin
      skip[i] = bf16_is_zero(ops_q[i]);
      pre[i] = bf16_is_zero(vec_operand[i*BF16_W +: BF16_W]) ? vec_operand[i*BF16_W +: BF16_W] : '0;
    end
`endif
  end
  sqrt_vec_lane_scan #(.LANES(LANES), .IW(IW)) u_issue_scan (.skip(skip), .idx(issue_q), .nxt(issue_ptr));
  sqrt_vec_lane_scan #(.LANES(LANES), .IW(IW)) u_collect_scan (.skip(skip), .idx(collect_q), .nxt(collect_ptr));
  assign vec_ready_in = state_q == IDLE;
  assign vec_valid_out = state_q == DONE;
  assign vec_result = res_q;
  assign sq_ready_out = state_q == RUN;
  assign sq_valid_in = state_q == RUN && issue_ptr < IW'(LANES) && inflight_q < FW'(MAX_INFLIGHT);
  assign sq_operand = sq_valid_in ? ops_q[issue_ptr[IW-2:0]] : '0;
  assign issue_fire = sq_valid_in && sq_ready_in;
  assign collect_fire = sq_ready_out && sq_valid_out && collect_ptr < IW'(LANES);
  // lanes still owed a response beyond the one being collected now
  assign rest = ~skip >> (collect_ptr + IW'(1));
  always_comb begin
    state_d = state_q;
    ops_d = ops_q;
    res_d = res_q;
    issue_d = issue_q;
    collect_d = collect_q;
    inflight_d = inflight_q;
    if (state_q == IDLE && vec_valid_in) begin
      state_d = RUN;
      ops_d = vec_operand;
      res_d = pre;
      issue_d = '0;
      collect_d = '0;
      inflight_d = '0;
    end
    if (state_q == RUN) begin
      issue_d = issue_fire ? issue_ptr + IW'(1) : issue_q;
      collect_d = collect_fire ? collect_ptr + IW'(1) : collect_q;
      inflight_d = inflight_q + FW'(issue_fire) - FW'(collect_fire);
      if (collect_fire) res_d[collect_ptr[IW-2:0]] = sq_result;
      if ((collect_fire && rest == '0) || collect_ptr == IW'(LANES)) state_d = DONE;
    end
    if (state_q == DONE && vec_ready_out) state_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ops_q <= '0;
      res_q <= '0;
      issue_q <= '0;
      collect_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      ops_q <= ops_d;
      res_q <= res_d;
      issue_q <= issue_d;
      collect_q <= collect_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_sqrt_vec_issue.sv
// tb_sqrt_vec_issue: scoreboard bench with a behavioural sqrt responder of configurable latency
module tb_sqrt_vec_issue;
  localparam int LANES = 16;
  localparam int VW = LANES * 16;
`ifdef SQRT_VEC_ZERO_SKIP_EN
  localparam int ZREQ = LANES / 2;
  localparam int AZREQ = 0;
`else
  localparam int ZREQ = LANES;
  localparam int AZREQ = LANES;
`endif
  logic clk = 0, rst = 1;
  logic vec_valid_in = 0, vec_ready_in, vec_valid_out, vec_ready_out = 1;
  logic [VW-1:0] vec_operand = '0, vec_result;
  logic [15:0] sq_operand, sq_result;
  logic sq_valid_in, sq_ready_in, sq_valid_out, sq_ready_out;
  int tests = 0, fails = 0, cyc = 0;
  int lat = 1, req_cnt = 0, max_out = 0, stab_err = 0;
  bit toggle = 0, flush = 0;
  logic [VW-1:0] exp_q[$];
  int due_q[$];
  logic [15:0] rsp_q[$];

  sqrt_vec_issue #(.LANES(LANES), .MAX_INFLIGHT(4)) dut (
    .CLK(clk), .RST(rst), .vec_valid_in(vec_valid_in), .vec_ready_in(vec_ready_in),
    .vec_operand(vec_operand), .vec_valid_out(vec_valid_out), .vec_ready_out(vec_ready_out),
    .vec_result(vec_result), .sq_operand(sq_operand), .sq_valid_in(sq_valid_in),
    .sq_ready_in(sq_ready_in), .sq_valid_out(sq_valid_out), .sq_ready_out(sq_ready_out),
    .sq_result(sq_result));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] sqrt_tab(input logic [15:0] x);
    case (x)
      16'h4080: return 16'h4000;
      16'h3F80: return 16'h3F80;
      16'h4180: return 16'h4080;
      16'h4110: return 16'h4040;
      16'h0000: return 16'h0000;
      16'h8000: return 16'h8000;
      default:  return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [VW-1:0] mk(input logic [15:0] a, b, c, d, r);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*16 +: 16] = r;
    v[15:0] = a;
    v[31:16] = b;
    v[47:32] = c;
    v[63:48] = d;
    return v;
  endfunction

  // responder: samples handshakes mid-cycle, updates its outputs just after the edge
  initial begin
    bit req, rsp;
    logic [15:0] rop;
    sq_valid_out = 0; sq_ready_in = 0; sq_result = 0;
    forever begin
      @(negedge clk);
      req = sq_valid_in && sq_ready_in;
      rop = sq_operand;
      rsp = sq_valid_out && sq_ready_out;
      @(posedge clk);
      #2;
      if (flush) begin
        due_q.delete();
        rsp_q.delete();
      end else begin
        if (rsp) begin
          void'(due_q.pop_front());
          void'(rsp_q.pop_front());
        end
        if (req) begin
          due_q.push_back(cyc + lat - 1);
          rsp_q.push_back(sqrt_tab(rop));
          req_cnt++;
        end
      end
      if (due_q.size() > max_out) max_out = due_q.size();
      sq_valid_out = due_q.size() > 0 && due_q[0] <= cyc;
      sq_result = sq_valid_out ? rsp_q[0] : 16'h0;
      sq_ready_in = toggle ? cyc[0] : 1'b1;
    end
  end

  // scoreboard monitor and request-stability watcher
  always @(negedge clk) begin
    if (!rst && vec_valid_out && vec_ready_out) begin
      if (exp_q.size() == 0) check("unexpected_vec", vec_result, '0 - 1);
      else check("vec_result", vec_result, exp_q.pop_front());
    end
  end
  initial begin
    bit pend = 0;
    logic [15:0] pop_v = 0;
    forever begin
      @(negedge clk);
      if (!rst && pend && !(sq_valid_in && sq_operand == pop_v)) stab_err++;
      pend = !rst && sq_valid_in && !sq_ready_in;
      pop_v = sq_operand;
    end
  end

  task automatic send_vec(input logic [VW-1:0] v, input logic [VW-1:0] e);
    int n = 0;
    while (!vec_ready_in && n < 50) begin
      @(posedge clk); #1; n++;
    end
    vec_valid_in = 1;
    vec_operand = v;
    exp_q.push_back(e);
    @(posedge clk); #1;
    vec_valid_in = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!vec_valid_out && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("done_seen", {255'b0, vec_valid_out}, 1);
  endtask

  initial begin
    int n, base, zc;
    logic [VW-1:0] v1, e1, zv, snap;
    logic ok_rdy, ok_res;
    bit saw_stale;
    v1 = mk(16'h4080, 16'h3F80, 16'h4180, 16'h4110, 16'h3F80);
    e1 = mk(16'h4000, 16'h3F80, 16'h4080, 16'h4040, 16'h3F80);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_in", {255'b0, vec_ready_in}, 1);
    check("rst_valid_out", {255'b0, vec_valid_out}, 0);
    check("rst_sq_valid_in", {255'b0, sq_valid_in}, 0);
    rst = 0;

    base = req_cnt;
    send_vec(v1, e1);
    wait_done(n);
    check("latency", n + 1, LANES + 2);
    @(posedge clk); #3;
    check("basic_req_count", req_cnt - base, LANES);

    lat = 6; toggle = 1;
    send_vec(v1, e1);
    wait_done(n);
    check("max_inflight_ok", {255'b0, max_out <= 4}, 1);
    check("sq_operand_stable", stab_err, 0);
    @(posedge clk); #1;
    lat = 1; toggle = 0;

    vec_ready_out = 0;
    send_vec(v1, e1);
    wait_done(n);
    snap = vec_result;
    ok_rdy = 1; ok_res = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (vec_ready_in || !vec_valid_out) ok_rdy = 0;
      if (vec_result !== snap) ok_res = 0;
    end
    check("stall_ready_in_low", {255'b0, ok_rdy}, 1);
    check("stall_result_stable", {255'b0, ok_res}, 1);
    vec_ready_out = 1;
    @(posedge clk); #1;
    check("release_idle", {255'b0, vec_ready_in}, 1);
    check("release_valid_low", {255'b0, vec_valid_out}, 0);

    lat = 20;
    base = req_cnt;
    send_vec(v1, e1);
    n = 0;
    while (req_cnt - base < 3 && n < 50) begin
      @(posedge clk); #3; n++;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    void'(exp_q.pop_back());
    check("mid_rst_ready_in", {255'b0, vec_ready_in}, 1);
    check("mid_rst_valid_out", {255'b0, vec_valid_out}, 0);
    check("mid_rst_result", vec_result, '0);
    check("mid_rst_sq_valid_in", {255'b0, sq_valid_in}, 0);
    check("mid_rst_sq_operand", {240'b0, sq_operand}, 0);
    check("mid_rst_sq_ready_out", {255'b0, sq_ready_out}, 0);
    saw_stale = 0; ok_rdy = 1;
    repeat (25) begin
      @(posedge clk); #3;
      saw_stale |= sq_valid_out;
      if (!vec_ready_in || vec_valid_out || sq_ready_out || vec_result !== '0) ok_rdy = 0;
    end
    check("stale_presented", {255'b0, saw_stale}, 1);
    check("stale_ignored", {255'b0, ok_rdy}, 1);
    flush = 1; lat = 1;
    @(posedge clk); #3;
    flush = 0;
    send_vec(v1, e1);
    wait_done(n);
    @(posedge clk); #1;

    for (int i = 0; i < LANES; i++) begin
      zv[i*16 +: 16] = i[0] ? 16'h4080 : (i[1] ? 16'h8000 : 16'h0000);
      snap[i*16 +: 16] = i[0] ? 16'h4000 : zv[i*16 +: 16];
    end
    base = req_cnt;
    send_vec(zv, snap);
    wait_done(n);
    @(posedge clk); #3;
    zc = req_cnt - base;
    check("zero_mix_req_count", zc, ZREQ);

    base = req_cnt;
    send_vec('0, '0);
    wait_done(n);
    @(posedge clk); #3;
    zc = req_cnt - base;
    check("all_zero_req_count", zc, AZREQ);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
